// File: rtl/lz4_match_copier.sv
// LZ4 match/literal copier: replays back-referenced bytes out of a history RAM and
// appends every emitted byte (literal or copied) to that history.
module lz4_match_copier #(
  parameter int unsigned AW = 7,
  parameter int unsigned LW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_offset,
  input  logic [LW-1:0] cmd_len,
  input  logic          lit_valid,
  output logic          lit_ready,
  input  logic [7:0]    lit_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic          ram_we_a,
  output logic [AW-1:0] ram_addr_a,
  output logic [7:0]    ram_data_a,
  output logic [AW-1:0] ram_addr_b,
  input  logic [7:0]    ram_q_b,
  output logic          done,
  output logic          err_offset
);

  typedef enum logic [1:0] {StIdle, StRd, StCap, StOut} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] offset_q, offset_d;
  logic [LW-1:0] remain_q, remain_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          cmd_fire, lit_fire, out_fire;

  assign cmd_ready = (state_q == StIdle);
  assign lit_ready = (state_q == StIdle) && !cmd_valid;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign lit_fire  = lit_valid && lit_ready;
  assign out_fire  = (state_q == StOut) && out_ready;

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign done       = done_q;
  assign err_offset = err_q;

  // Every emitted byte is written back at the write pointer on its handshake, so an
  // overlapping match reads its own freshly written bytes on the following RD.
  assign ram_we_a   = out_fire;
  assign ram_addr_a = wptr_q;
  assign ram_data_a = data_q;
  assign ram_addr_b = wptr_q - offset_q;

  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    offset_d = offset_q;
    remain_d = remain_q;
    data_d   = data_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    err_d    = err_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_fire) begin
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else if (cmd_offset == '0) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            offset_d = cmd_offset;
            remain_d = cmd_len;
            state_d  = StRd;
          end
        end else if (lit_fire) begin
          data_d   = lit_data;
          valid_d  = 1'b1;
          remain_d = LW'(1);
          state_d  = StOut;
        end
      end
      StRd: begin
        state_d = StCap;
      end
      StCap: begin
        data_d  = ram_q_b;
        valid_d = 1'b1;
        state_d = StOut;
      end
      StOut: begin
        if (out_ready) begin
          wptr_d   = wptr_q + 1'b1;
          remain_d = remain_q - 1'b1;
          valid_d  = 1'b0;
          if (remain_q == LW'(1)) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StRd;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      wptr_q   <= '0;
      offset_q <= '0;
      remain_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      offset_q <= offset_d;
      remain_q <= remain_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_lz4_match_copier.sv
// Directed bench for lz4_match_copier with a behavioural history RAM and
// hand-computed expected output/write sequences.
module tb_lz4_match_copier;

  localparam int unsigned AW = 7;
  localparam int unsigned LW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_offset;
  logic [LW-1:0] cmd_len;
  logic          lit_valid, lit_ready;
  logic [7:0]    lit_data;
  logic          out_valid, out_ready;
  logic [7:0]    out_data;
  logic          ram_we_a;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic [7:0]    ram_data_a, ram_q_b;
  logic          done, err_offset;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]    mem [0:(1<<AW)-1];
  logic [7:0]    out_q [$];
  logic [AW-1:0] wa_q [$];
  logic [7:0]    wd_q [$];
  int            done_cnt = 0;
  int            valid_cnt = 0;

  always #5 clk = ~clk;

  lz4_match_copier #(.AW(AW), .LW(LW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_offset (cmd_offset),
    .cmd_len    (cmd_len),
    .lit_valid  (lit_valid),
    .lit_ready  (lit_ready),
    .lit_data   (lit_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .ram_we_a   (ram_we_a),
    .ram_addr_a (ram_addr_a),
    .ram_data_a (ram_data_a),
    .ram_addr_b (ram_addr_b),
    .ram_q_b    (ram_q_b),
    .done       (done),
    .err_offset (err_offset)
  );

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
  end

  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
    ram_q_b <= mem[ram_addr_b];
  end

  // Inputs only move at posedge+1, so negedge values are what the next edge sees.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) out_q.push_back(out_data);
      if (ram_we_a) begin
        wa_q.push_back(ram_addr_a);
        wd_q.push_back(ram_data_a);
      end
      if (done) done_cnt++;
      if (out_valid) valid_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send_lit(input logic [7:0] d);
    int n = 0;
    lit_valid = 1'b1;
    lit_data  = d;
    while (!lit_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check_eq("lit_accept", 32'(lit_ready), 1);
    @(posedge clk); #1;
    lit_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [AW-1:0] off, input logic [LW-1:0] len);
    int n = 0;
    cmd_valid  = 1'b1;
    cmd_offset = off;
    cmd_len    = len;
    while (!cmd_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check_eq("cmd_accept", 32'(cmd_ready), 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input string tag);
    int n = 0;
    while (done_cnt < target && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    check_eq(tag, 32'(done_cnt >= target), 1);
  endtask

  initial begin
    int ob, wb, db, vb, n;
    logic [7:0] exp_out [];
    cmd_valid = 0; cmd_offset = '0; cmd_len = '0;
    lit_valid = 0; lit_data = '0; out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_out_valid", 32'(out_valid), 0);
    do_reset();
    check_eq("rst_out_valid", 32'(out_valid), 0);
    check_eq("rst_out_data", 32'(out_data), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_err", 32'(err_offset), 0);
    check_eq("rst_we", 32'(ram_we_a), 0);
    check_eq("rst_cmd_ready", 32'(cmd_ready), 1);

    // Literals then a non-overlapping match.
    ob = out_q.size(); wb = wa_q.size(); db = done_cnt;
    send_lit(8'h41); send_lit(8'h42); send_lit(8'h43);
    send_cmd(7'd3, 16'd3);
    wait_done(db + 4, "t1_done");
    exp_out = '{8'h41, 8'h42, 8'h43, 8'h41, 8'h42, 8'h43};
    check_eq("t1_nout", out_q.size() - ob, 6);
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("t1_out%0d", i), 32'(out_q[ob+i]), 32'(exp_out[i]));
      check_eq($sformatf("t1_wa%0d", i), 32'(wa_q[wb+i]), i);
    end
    repeat (3) @(posedge clk); #1;
    check_eq("t1_done_cnt", done_cnt - db, 4);

    // Offset 1 overlap: run of repeated bytes.
    do_reset();
    ob = out_q.size(); wb = wa_q.size(); db = done_cnt;
    send_lit(8'h5A);
    send_cmd(7'd1, 16'd4);
    wait_done(db + 2, "t2_done");
    check_eq("t2_nout", out_q.size() - ob, 5);
    for (int i = 0; i < 5; i++) check_eq($sformatf("t2_out%0d", i), 32'(out_q[ob+i]), 32'h5A);
    send_lit(8'h11);
    wait_done(db + 3, "t2_done2");
    check_eq("t2_wptr5", 32'(wa_q[wa_q.size()-1]), 5);

    // Read address wraps below zero.
    do_reset();
    for (int i = 0; i < 130; i++) send_lit(8'(i));
    db = done_cnt;
    wait_done(db, "t3_lits");
    repeat (2) @(posedge clk); #1;
    ob = out_q.size(); wb = wa_q.size(); db = done_cnt;
    send_cmd(7'd4, 16'd4);
    wait_done(db + 1, "t3_done");
    exp_out = '{8'h7E, 8'h7F, 8'h80, 8'h81};
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t3_out%0d", i), 32'(out_q[ob+i]), 32'(exp_out[i]));
      check_eq($sformatf("t3_wa%0d", i), 32'(wa_q[wb+i]), 2 + i);
    end

    // Zero length and zero offset commands.
    do_reset();
    wb = wa_q.size(); vb = valid_cnt;
    send_cmd(7'd3, 16'd0);
    check_eq("t4_len0_done", 32'(done), 1);
    check_eq("t4_len0_err", 32'(err_offset), 0);
    send_cmd(7'd0, 16'd5);
    check_eq("t4_off0_done", 32'(done), 1);
    check_eq("t4_off0_err", 32'(err_offset), 1);
    repeat (4) @(posedge clk); #1;
    check_eq("t4_no_valid", valid_cnt - vb, 0);
    check_eq("t4_no_write", wa_q.size() - wb, 0);
    check_eq("t4_err_sticky", 32'(err_offset), 1);
    check_eq("t4_idle", 32'(cmd_ready), 1);

    // Downstream backpressure during a match byte.
    do_reset();
    db = done_cnt;
    send_lit(8'h01); send_lit(8'h02);
    wait_done(db + 2, "t5_lits");
    ob = out_q.size(); wb = wa_q.size();
    out_ready = 1'b0;
    send_cmd(7'd2, 16'd2);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq($sformatf("t5_hold_data%0d", i), 32'(out_data), 32'h01);
      check_eq($sformatf("t5_hold_we%0d", i), 32'(ram_we_a), 0);
      check_eq($sformatf("t5_hold_valid%0d", i), 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    wait_done(db + 3, "t5_done");
    exp_out = '{8'h01, 8'h02};
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("t5_out%0d", i), 32'(out_q[ob+i]), 32'(exp_out[i]));
      check_eq($sformatf("t5_wa%0d", i), 32'(wa_q[wb+i]), 2 + i);
    end

    // Reset in the middle of a six-byte match.
    do_reset();
    wb = wa_q.size();
    send_lit(8'hAA); send_lit(8'hBB);
    send_cmd(7'd2, 16'd6);
    n = 0;
    while (wa_q.size() < wb + 4 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check_eq("t6_two_written", wa_q.size() - wb, 4);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_valid", 32'(out_valid), 0);
    check_eq("t6_rst_data", 32'(out_data), 0);
    check_eq("t6_rst_done", 32'(done), 0);
    check_eq("t6_rst_err", 32'(err_offset), 0);
    check_eq("t6_rst_we", 32'(ram_we_a), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_eq("t6_no_more_writes", wa_q.size() - wb, 4);
    check_eq("t6_mem2", 32'(mem[2]), 32'hAA);
    check_eq("t6_mem3", 32'(mem[3]), 32'hBB);
    db = done_cnt;
    send_lit(8'h77);
    wait_done(db + 1, "t6_done");
    check_eq("t6_new_addr", 32'(wa_q[wa_q.size()-1]), 0);
    check_eq("t6_new_data", 32'(wd_q[wd_q.size()-1]), 32'h77);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lz4_match_copier.md
LZ4_MATCH_COPIER -- requirements
Module: lz4_match_copier

Interface
REQ-001 SHALL have parameter AW, default 7, meaning history address width (depth 2^AW bytes).
REQ-002 SHALL have parameter LW, default 16, meaning match length width.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_valid  input  1  match command present.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when both high.
REQ-007 SHALL have port cmd_offset  input  AW  match distance back from write pointer.
REQ-008 SHALL have port cmd_len  input  LW  match byte count.
REQ-009 SHALL have port lit_valid  input  1  literal byte present.
REQ-010 SHALL have port lit_ready  output  1  literal accepted when both high.
REQ-011 SHALL have port lit_data  input  8  literal byte.
REQ-012 SHALL have port out_valid  output  1  decoded byte present.
REQ-013 SHALL have port out_ready  input  1  downstream accepts byte.
REQ-014 SHALL have port out_data  output  8  decoded byte, registered.
REQ-015 SHALL have ports ram_we_a  output  1, ram_addr_a  output  AW, ram_data_a  output  8  history write port.
REQ-016 SHALL have ports ram_addr_b  output  AW, ram_q_b  input  8  history read port; q valid one cycle after address.
REQ-017 SHALL have ports done  output  1  one-cycle pulse on command/literal completion; err_offset  output  1  sticky.

Function
REQ-018 SHALL implement states IDLE, RD, CAP, OUT; internal wptr (AW bits), remain (LW bits).
REQ-019 SHALL drive cmd_ready = (state==IDLE); lit_ready = (state==IDLE && !cmd_valid); commands have priority over literals.
REQ-020 IDLE, cmd accepted, cmd_len==0: SHALL pulse done next cycle, no output, no RAM write, stay IDLE.
REQ-021 IDLE, cmd accepted, cmd_offset==0 (len>0): SHALL set err_offset, pulse done next cycle, no output, stay IDLE.
REQ-022 IDLE, valid cmd accepted: SHALL latch offset, remain<=cmd_len, go RD.
REQ-023 IDLE, literal accepted: SHALL latch out_data<=lit_data, out_valid<=1, remain<=1, go OUT (bypasses RAM read).
REQ-024 RD: SHALL drive ram_addr_b = (wptr - offset) mod 2^AW for one cycle, go CAP.
REQ-025 CAP: SHALL latch out_data<=ram_q_b, out_valid<=1, go OUT.
REQ-026 OUT: SHALL hold out_valid and out_data stable until out_ready; no RAM write while out_ready low.
REQ-027 OUT handshake cycle: SHALL assert ram_we_a with ram_addr_a=wptr, ram_data_a=out_data; at edge wptr<=wptr+1 (wraps 2^AW-1 -> 0), remain<=remain-1, out_valid<=0.
REQ-028 After handshake: remain was 1 -> done pulse next cycle, go IDLE; else go RD.
REQ-029 Overlapping matches (offset < len, incl. offset 1) SHALL reproduce repeated bytes correctly; write completes before next RD, no bypass needed.
REQ-030 Throughput SHALL be one match byte per 3 cycles with out_ready high; one literal per 2 cycles.
REQ-031 Offsets exceeding bytes written since reset SHALL NOT be detected; stale RAM contents are emitted.
REQ-032 ram_we_a SHALL be 0 in every cycle other than an OUT handshake; ram_addr_b SHALL be don't-care outside RD.

Reset
REQ-033 rst_n low SHALL asynchronously force IDLE, wptr=0, remain=0, out_valid=0, out_data=0, done=0, err_offset=0, ram_we_a=0.
REQ-034 Reset mid-command SHALL abort without further RAM writes; bytes already written remain in RAM.
REQ-035 err_offset SHALL clear only on reset.

Verification
REQ-036 Literals 0x41,0x42,0x43 then cmd offset=3 len=3 -> out 41 42 43 41 42 43; RAM writes addr 0..5; done after each literal and once after match.
REQ-037 Literal 0x5A then cmd offset=1 len=4 -> out 5A 5A 5A 5A 5A; wptr=5.
REQ-038 130 literals 0x00..0x81 (wptr=2), cmd offset=4 len=4 -> reads addr 126,127,0,1 -> out 7E 7F 80 81.
REQ-039 cmd len=0 -> done pulse, no out_valid; cmd offset=0 len=5 -> err_offset=1, done pulse, no output, no ram_we_a.
REQ-040 out_ready low 5 cycles during a match byte -> out_data stable, ram_we_a=0, wptr unchanged; resumes correctly.
REQ-041 rst_n low after 2 of 6 match bytes -> all outputs zero immediately; new literal after release written to addr 0.
